// File: rtl/audio_stream_pkg.sv
// Shared types and default parameter values for the audio sample streamer.
// The FSM state enum is exported so checkers and benches can decode state_dbg.
package audio_stream_pkg;

  localparam int ADDR_W_DEF     = 23;
  localparam int DATA_W_DEF     = 32;
  localparam int SAMPLE_W_DEF   = 8;
  localparam int UNDERRUN_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    ADVANCE,
    WRAP,
    PAUSED,
    DONE
  } state_t;

  // Lane index width; a single-lane word still needs a 1-bit index.
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/sample_lane_mux.sv
// Word buffer plus lane selection and mute for the audio sample streamer.
// Captures a fetched word on load and registers one selected lane per emit.
module sample_lane_mux
  import audio_stream_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int LANE_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [DATA_W-1:0]   word_in,
  input  logic                emit,
  input  logic [LANE_W-1:0]   lane,
  input  logic                mute,
  output logic [SAMPLE_W-1:0] sample_out
);

  localparam int LANES = DATA_W / SAMPLE_W;

  logic [DATA_W-1:0]   word_buf;
  logic [SAMPLE_W-1:0] lane_sel;

  // Lane 0 is the least significant slice of the word.
  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < LANES; i++) begin
      if (int'(lane) == i) lane_sel = word_buf[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_buf   <= '0;
      sample_out <= '0;
    end else begin
      if (load) word_buf <= word_in;
      if (emit) sample_out <= mute ? '0 : lane_sel;
    end
  end

endmodule

// File: rtl/audio_sample_streamer.sv
// Streams packed audio samples from word memory over an inclusive address range,
// one sample per sample_tick, with pause/mute, looping via a wrap handshake and underrun counting.
module audio_sample_streamer
  import audio_stream_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int UNDERRUN_W = UNDERRUN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  input  logic                  dir,
  input  logic                  loop_en,
  input  logic                  pause,
  input  logic                  mute,
  input  logic                  restart,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_data,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  sample_valid,
  output logic                  wrap_req,
  input  logic                  wrap_ack,
  output logic                  busy,
  output logic                  done,
  output logic [UNDERRUN_W-1:0] underrun_count,
  output state_t                state_dbg
);

  localparam int LANES  = DATA_W / SAMPLE_W;
  localparam int LANE_W = lane_idx_w(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  // Handshakes: mem_req and wrap_req are registered levels that stay high until
  // the matching ack is seen on a rising edge; an ack while the request is low is ignored.
  state_t              state, next_state;
  logic [ADDR_W-1:0]   start_q, end_q;
  logic                dir_q;
  logic [LANE_W-1:0]   lane;
  logic                fetch_done, emit, bound_hit, underrun_hit, starving;

  assign fetch_done   = (state == FETCH) && mem_req && mem_ack && !restart;
  assign emit         = (state == PLAY) && sample_tick && !pause && !restart;
  assign bound_hit    = dir_q ? (mem_addr <= start_q) : (mem_addr >= end_q);
  assign starving     = (state == FETCH) || (state == ADVANCE) || (state == WRAP);
  assign underrun_hit = starving && sample_tick && !pause && !restart;

  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_comb begin
    next_state = state;
    if (restart) begin
      next_state = FETCH;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        DONE:    next_state = DONE;
        FETCH:   if (fetch_done) next_state = PLAY;
        PLAY:    if (emit && (lane == LAST_LANE)) next_state = ADVANCE;
        ADVANCE: begin
          if (bound_hit) next_state = loop_en ? WRAP : DONE;
          else           next_state = pause ? PAUSED : FETCH;
        end
        WRAP:    if (wrap_ack) next_state = pause ? PAUSED : FETCH;
        PAUSED:  if (!pause) next_state = FETCH;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mem_addr       <= '0;
      start_q        <= '0;
      end_q          <= '0;
      dir_q          <= 1'b0;
      lane           <= '0;
      mem_req        <= 1'b0;
      wrap_req       <= 1'b0;
      sample_valid   <= 1'b0;
      underrun_count <= '0;
    end else begin
      state        <= next_state;
      // A restart drops both requests for one cycle so a coincident ack is discarded.
      mem_req      <= (next_state == FETCH) && !restart;
      wrap_req     <= (next_state == WRAP) && !restart;
      sample_valid <= emit;

      if (restart) begin
        start_q        <= start_addr;
        end_q          <= end_addr;
        dir_q          <= dir;
        mem_addr       <= dir ? end_addr : start_addr;
        lane           <= '0;
        underrun_count <= '0;
      end else begin
        if (underrun_hit && (underrun_count != '1))
          underrun_count <= underrun_count + 1'b1;

        if (fetch_done)  lane <= '0;
        else if (emit)   lane <= lane + 1'b1;

        if ((state == ADVANCE) && !bound_hit)
          mem_addr <= dir_q ? (mem_addr - 1'b1) : (mem_addr + 1'b1);

        if ((state == WRAP) && wrap_ack) begin
          start_q  <= start_addr;
          end_q    <= end_addr;
          dir_q    <= dir;
          mem_addr <= dir ? end_addr : start_addr;
        end
      end
    end
  end

  sample_lane_mux #(
    .DATA_W  (DATA_W),
    .SAMPLE_W(SAMPLE_W),
    .LANE_W  (LANE_W)
  ) u_lane_mux (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (fetch_done),
    .word_in   (mem_data),
    .emit      (emit),
    .lane      (lane),
    .mute      (mute),
    .sample_out(sample_out)
  );

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Directed bench for audio_sample_streamer: table-driven play sessions plus
// hand-written pause, underrun, restart, wrap and reset sequences.
module tb_audio_sample_streamer;
  import audio_stream_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [22:0] start_addr = '0;
  logic [22:0] end_addr = '0;
  logic        dir = 1'b0;
  logic        loop_en = 1'b0;
  logic        pause = 1'b0;
  logic        mute = 1'b0;
  logic        restart = 1'b0;
  logic        restart2 = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        wrap_ack = 1'b0;

  logic [22:0] mem_addr, mem_addr2;
  logic        mem_req, mem_req2;
  logic [7:0]  sample_out;
  logic [15:0] sample_out2;
  logic        sample_valid, sample_valid2;
  logic        wrap_req, wrap_req2;
  logic        busy, busy2, done, done2;
  logic [15:0] underrun_count;
  logic [1:0]  underrun_count2;
  state_t      state_dbg, state_dbg2;

  always #5 clk = ~clk;

  audio_sample_streamer u_dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .start_addr(start_addr), .end_addr(end_addr), .dir(dir), .loop_en(loop_en),
    .pause(pause), .mute(mute), .restart(restart),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
    .sample_out(sample_out), .sample_valid(sample_valid),
    .wrap_req(wrap_req), .wrap_ack(wrap_ack), .busy(busy), .done(done),
    .underrun_count(underrun_count), .state_dbg(state_dbg)
  );

  // Second instance: 16-bit samples and a 2-bit underrun counter; only restart2 wakes it.
  audio_sample_streamer #(.SAMPLE_W(16), .UNDERRUN_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .start_addr(start_addr), .end_addr(end_addr), .dir(dir), .loop_en(loop_en),
    .pause(pause), .mute(mute), .restart(restart2),
    .mem_addr(mem_addr2), .mem_req(mem_req2), .mem_ack(mem_ack), .mem_data(mem_data),
    .sample_out(sample_out2), .sample_valid(sample_valid2),
    .wrap_req(wrap_req2), .wrap_ack(wrap_ack), .busy(busy2), .done(done2),
    .underrun_count(underrun_count2), .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard / counters ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart(input logic [22:0] st, input logic [22:0] en, input logic dr);
    start_addr = st;
    end_addr   = en;
    dir        = dr;
    restart    = 1'b1;
    step();
    restart    = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (!mem_req && k < 20) begin
      step();
      k++;
    end
    check({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
  endtask

  task automatic tick_once();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  // Fetch one word at exp_addr and play its four 8-bit lanes on back-to-back ticks.
  task automatic serve_word(input logic [22:0] exp_addr, input logic [31:0] data,
                            input logic [31:0] exp_word, input string tag);
    wait_req(tag);
    check({tag, " addr"}, {9'd0, mem_addr}, {9'd0, exp_addr});
    mem_data = data;
    mem_ack  = 1'b1;
    step();
    mem_ack  = 1'b0;
    check({tag, " state after ack"}, state_dbg, PLAY);
    check({tag, " req dropped"}, {31'd0, mem_req}, 32'd0);
    for (int l = 0; l < 4; l++) begin
      tick_once();
      check($sformatf("%s lane%0d sample", tag, l), {24'd0, sample_out}, {24'd0, exp_word[l*8 +: 8]});
      check($sformatf("%s lane%0d valid", tag, l), {31'd0, sample_valid}, 32'd1);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rs;
    logic [22:0] st;
    logic [22:0] en;
    logic        dr;
    logic [22:0] addr;
    logic [31:0] data;
    logic        mt;
    logic [31:0] exp;
    logic        last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 23'h10, 23'h11, 1'b0, 23'h10, 32'h44332211, 1'b0, 32'h44332211, 1'b0};
    vecs[1] = '{1'b0, 23'h10, 23'h11, 1'b0, 23'h11, 32'hA1B2C3D4, 1'b0, 32'hA1B2C3D4, 1'b1};
    vecs[2] = '{1'b1, 23'h05, 23'h06, 1'b0, 23'h05, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b0};
    vecs[3] = '{1'b0, 23'h05, 23'h06, 1'b0, 23'h06, 32'h01020304, 1'b0, 32'h01020304, 1'b1};
    vecs[4] = '{1'b1, 23'h31, 23'h32, 1'b1, 23'h32, 32'h55667788, 1'b0, 32'h55667788, 1'b0};
    vecs[5] = '{1'b0, 23'h31, 23'h32, 1'b1, 23'h31, 32'h0F0E0D0C, 1'b0, 32'h0F0E0D0C, 1'b1};

    // ---- reset state ----
    step();
    step();
    check("rst state", state_dbg, IDLE);
    check("rst mem_addr", {9'd0, mem_addr}, 32'd0);
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst sample_out", {24'd0, sample_out}, 32'd0);
    check("rst valid", {31'd0, sample_valid}, 32'd0);
    check("rst wrap_req", {31'd0, wrap_req}, 32'd0);
    check("rst busy/done", {30'd0, busy, done}, 32'd0);
    check("rst underrun", {16'd0, underrun_count}, 32'd0);
    rst_n = 1'b1;

    // ---- IDLE ignores everything but restart ----
    for (int c = 0; c < 4; c++) begin
      sample_tick = 1'b1;
      mem_ack     = c[0];
      wrap_ack    = 1'b1;
      step();
    end
    sample_tick = 1'b0;
    mem_ack     = 1'b0;
    wrap_ack    = 1'b0;
    check("idle hold state", state_dbg, IDLE);
    check("idle underrun", {16'd0, underrun_count}, 32'd0);
    check("idle mem_req", {31'd0, mem_req}, 32'd0);

    // ---- table-driven play sessions (forward, mute, reverse) ----
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rs) pulse_restart(vecs[i].st, vecs[i].en, vecs[i].dr);
      mute = vecs[i].mt;
      serve_word(vecs[i].addr, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
      if (vecs[i].last) begin
        step();
        check($sformatf("vec%0d done", i), {31'd0, done}, 32'd1);
        check($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd0);
        check($sformatf("vec%0d final addr", i), {9'd0, mem_addr}, {9'd0, vecs[i].addr});
        check($sformatf("vec%0d valid pulse end", i), {31'd0, sample_valid}, 32'd0);
      end
    end
    mute = 1'b0;

    // ---- pause in PLAY: ticks ignored, no underrun ----
    pulse_restart(23'h50, 23'h50, 1'b0);
    wait_req("pause");
    mem_data = 32'h88776655;
    mem_ack  = 1'b1;
    step();
    mem_ack  = 1'b0;
    tick_once();
    check("pause lane0", {24'd0, sample_out}, 32'h55);
    pause = 1'b1;
    for (int p = 0; p < 3; p++) begin
      step();
      if (p == 0) check("valid one cycle", {31'd0, sample_valid}, 32'd0);
      tick_once();
      check($sformatf("paused tick%0d valid", p), {31'd0, sample_valid}, 32'd0);
      check($sformatf("paused tick%0d hold", p), {24'd0, sample_out}, 32'h55);
    end
    check("paused state", state_dbg, PLAY);
    check("paused underrun", {16'd0, underrun_count}, 32'd0);
    pause = 1'b0;
    for (int l = 1; l < 4; l++) begin
      tick_once();
      check($sformatf("resume lane%0d", l), {24'd0, sample_out}, 32'h55 + 32'(l) * 32'h11);
      check($sformatf("resume lane%0d valid", l), {31'd0, sample_valid}, 32'd1);
    end
    step();
    check("pause session done", {31'd0, done}, 32'd1);

    // ---- delayed ack with a tick every 2 cycles ----
    pulse_restart(23'h60, 23'h60, 1'b0);
    wait_req("delay");
    mem_data = 32'h11111111;
    for (int c = 1; c <= 5; c++) begin
      sample_tick = (c % 2 == 0);
      mem_ack     = (c == 5);
      step();
    end
    sample_tick = 1'b0;
    mem_ack     = 1'b0;
    check("delay underrun", {16'd0, underrun_count}, 32'd2);
    check("delay state", state_dbg, PLAY);

    // ---- restart coinciding with a tick: no sample, no underrun ----
    sample_tick = 1'b1;
    pulse_restart(23'h60, 23'h60, 1'b0);
    sample_tick = 1'b0;
    check("restart+tick valid", {31'd0, sample_valid}, 32'd0);
    check("restart+tick underrun", {16'd0, underrun_count}, 32'd0);
    check("restart+tick state", state_dbg, FETCH);
    check("restart+tick req", {31'd0, mem_req}, 32'd0);

    // ---- restart coinciding with mem_ack: data discarded, refetch at new start ----
    step();
    check("pre-collision req", {31'd0, mem_req}, 32'd1);
    mem_data = 32'hBADBAD00;
    mem_ack  = 1'b1;
    pulse_restart(23'h70, 23'h70, 1'b0);
    check("collision state", state_dbg, FETCH);
    check("collision req", {31'd0, mem_req}, 32'd0);
    check("collision addr", {9'd0, mem_addr}, 32'h70);
    step();
    mem_ack = 1'b0;
    check("ack ignored w/o req", state_dbg, FETCH);
    serve_word(23'h70, 32'h0D0C0B0A, 32'h0D0C0B0A, "refetch");
    step();
    check("refetch done", {31'd0, done}, 32'd1);

    // ---- reverse loop with wrap handshake, then reset inside WRAP ----
    loop_en = 1'b1;
    pulse_restart(23'h20, 23'h22, 1'b1);
    serve_word(23'h22, 32'h04030201, 32'h04030201, "rev22");
    serve_word(23'h21, 32'h14131211, 32'h14131211, "rev21");
    serve_word(23'h20, 32'h24232221, 32'h24232221, "rev20");
    step();
    check("wrap state", state_dbg, WRAP);
    check("wrap_req set", {31'd0, wrap_req}, 32'd1);
    check("wrap busy", {31'd0, busy}, 32'd1);
    tick_once();
    step();
    check("wrap_req held", {31'd0, wrap_req}, 32'd1);
    check("wrap underrun", {16'd0, underrun_count}, 32'd1);
    start_addr = 23'h40;
    end_addr   = 23'h40;
    dir        = 1'b1;
    wrap_ack   = 1'b1;
    step();
    wrap_ack   = 1'b0;
    check("wrap_req dropped", {31'd0, wrap_req}, 32'd0);
    check("post-wrap state", state_dbg, FETCH);
    serve_word(23'h40, 32'h31323334, 32'h31323334, "wrap40");
    step();
    check("second wrap", state_dbg, WRAP);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst state", state_dbg, IDLE);
    check("async rst wrap_req", {31'd0, wrap_req}, 32'd0);
    check("async rst mem_addr", {9'd0, mem_addr}, 32'd0);
    check("async rst sample_out", {24'd0, sample_out}, 32'd0);
    check("async rst underrun", {16'd0, underrun_count}, 32'd0);
    check("async rst busy/done/req", {29'd0, busy, done, mem_req}, 32'd0);
    step();
    rst_n    = 1'b1;
    loop_en  = 1'b0;
    wrap_ack = 1'b1;
    mem_ack  = 1'b1;
    step();
    step();
    wrap_ack = 1'b0;
    mem_ack  = 1'b0;
    check("post-reset idle", state_dbg, IDLE);

    // ---- 16-bit lanes, mute, saturating 2-bit underrun counter ----
    check("dut2 idle state", state_dbg2, IDLE);
    check("dut2 idle underrun", {30'd0, underrun_count2}, 32'd0);
    start_addr = 23'h08;
    end_addr   = 23'h08;
    dir        = 1'b0;
    restart2   = 1'b1;
    step();
    restart2   = 1'b0;
    step();
    check("dut2 req", {31'd0, mem_req2}, 32'd1);
    for (int t = 0; t < 5; t++) tick_once();
    check("dut2 underrun sat", {30'd0, underrun_count2}, 32'd3);
    mem_data = 32'h12345678;
    mem_ack  = 1'b1;
    step();
    mem_ack  = 1'b0;
    check("dut2 play", state_dbg2, PLAY);
    mute = 1'b1;
    tick_once();
    check("dut2 muted sample", {16'd0, sample_out2}, 32'd0);
    check("dut2 muted valid", {31'd0, sample_valid2}, 32'd1);
    mute = 1'b0;
    tick_once();
    check("dut2 lane1", {16'd0, sample_out2}, 32'h1234);
    check("dut2 two lanes", state_dbg2, ADVANCE);
    step();
    check("dut2 done", {31'd0, done2}, 32'd1);
    check("dut2 final addr", {9'd0, mem_addr2}, 32'h08);
    check("dut1 ignored dut2 traffic", state_dbg, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
